// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - FSM encodings and default widths shared by dram_arbiter files
package dram_arbiter_pkg;

  localparam int DEF_N_CORES = 4;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_MEM_LAT = 1;

  // Wait counter only has to reach MEM_LAT-1 (MEM_LAT is at most 3).
  localparam int WAIT_W = 2;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of a core index; never zero so a 1-core build still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// rtl/dram_arbiter_rr_pick.sv - combinational round-robin picker for dram_arbiter
module dram_arbiter_rr_pick
  import dram_arbiter_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int IDX_W   = idx_width(DEF_N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [N_CORES-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               valid
);

  // Scan last+1, last+2, ... with wrap-around and take the first requester.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    index = '0;
    valid = 1'b0;
    for (int k = 1; k <= N_CORES; k++) begin
      j = (int'(last) + k) % N_CORES;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        index    = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one sync RAM among cores (stats: DRAM_ARB_STATS_EN)
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES*ADDR_W-1:0] addr_in,
  input  logic [N_CORES*DATA_W-1:0] wdata_in,
  output logic [N_CORES-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_rden,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q,
  output logic                      busy,
  output logic [N_CORES*STAT_W-1:0] stat_grant
);

  localparam int                IDX_W     = idx_width(N_CORES);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LAT - 1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   last;
  logic [N_CORES-1:0] win_oh;
  logic               lat_we;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               wait_done;
  logic [N_CORES-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [N_CORES-1:0] ack_d;
  logic               rden_d, wren_d;

  dram_arbiter_rr_pick #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last),
    .grant (pick_grant),
    .index (pick_idx),
    .valid (pick_valid)
  );

  assign wait_done = (wait_cnt == LAST_WAIT);

  // Next state plus the values the registered outputs take on entering it.
  always_comb begin
    state_d = state;
    ack_d   = '0;
    rden_d  = 1'b0;
    wren_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ISSUE;
          wren_d  = we[pick_idx];
          rden_d  = !we[pick_idx];
        end
      end
      ST_ISSUE: begin
        if (lat_we) begin
          state_d = ST_DONE;
          ack_d   = win_oh;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_done) begin
          state_d = ST_DONE;
          ack_d   = win_oh;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, grant latches (winner's we/addr/wdata), strobes and read capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      last      <= IDX_W'(N_CORES - 1);
      win_oh    <= '0;
      lat_we    <= 1'b0;
      wait_cnt  <= '0;
      ack       <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_d;
      ack      <= ack_d;
      mem_rden <= rden_d;
      mem_wren <= wren_d;
      busy     <= (state_d != ST_IDLE);
      if (state == ST_IDLE && pick_valid) begin
        last      <= pick_idx;
        win_oh    <= pick_grant;
        lat_we    <= we[pick_idx];
        mem_addr  <= addr_in[int'(pick_idx)*ADDR_W +: ADDR_W];
        mem_wdata <= wdata_in[int'(pick_idx)*DATA_W +: DATA_W];
      end
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == ST_WAIT && wait_done) begin
        rdata <= mem_q;
      end
    end
  end

`ifdef DRAM_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [N_CORES];

  // Saturating per-core grant counters, bumped on the same edge that raises ack.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (!reset_n) begin
        grant_cnt[i] <= '0;
      end else if (ack_d[i] && grant_cnt[i] != {STAT_W{1'b1}}) begin
        grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_stat
    assign stat_grant[g*STAT_W +: STAT_W] = grant_cnt[g];
  end
`else
  assign stat_grant = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - randomized self-checking bench for dram_arbiter against a transaction-level model
module tb_dram_arbiter;

  localparam int N   = 4;
  localparam int AW  = 9;
  localparam int DW  = 16;
  localparam int LAT = 1;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N*DW-1:0] wdata_in = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rden;
  logic            mem_wren;
  logic [DW-1:0]   mem_q;
  logic            busy;
  logic [N*16-1:0] stat_grant;

  dram_arbiter #(
    .N_CORES (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MEM_LAT (LAT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .we         (we),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .ack        (ack),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .busy       (busy),
    .stat_grant (stat_grant)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pattern(input int a);
    return DW'(a * 40503 + 257);
  endfunction

  // Sync RAM with one cycle of read latency, plus bench-only init and poke paths.
  logic [DW-1:0] ram [1<<AW];
  logic          ram_init = 1'b0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;

  // RAM behaviour: writes on mem_wren, registered read data on mem_rden.
  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= pattern(i);
    end else if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_rden) mem_q <= ram[mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Transaction-level reference: one transaction in flight, timed from the grant edge.
  logic [DW-1:0] shadow [1<<AW];
  bit            m_busy = 1'b0;
  int            m_s = 0, m_a = 0, m_next = 0;
  int            m_last = N - 1;
  int            m_core = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_stat [N];
  logic [N-1:0]  e_ack = '0;
  bit            e_wren = 1'b0, e_rden = 1'b0, e_strobe = 1'b0, e_rdv = 1'b0;
  logic [DW-1:0] e_rdata = '0;
  int            cd [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    e_ack = '0; e_wren = 1'b0; e_rden = 1'b0; e_strobe = 1'b0; e_rdv = 1'b0;
    if (!reset_n) begin
      m_busy = 1'b0;
      m_next = cyc + 1;
      m_last = N - 1;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
      return;
    end
    if (m_busy && cyc == m_a + 1) m_busy = 1'b0;
    if (!m_busy && cyc >= m_next) begin
      if (req != '0) begin
        m_core = -1;
        for (int k = 1; k <= N; k++)
          if (m_core < 0 && req[(m_last + k) % N]) m_core = (m_last + k) % N;
        m_last  = m_core;
        m_we    = we[m_core];
        m_addr  = addr_in[m_core*AW +: AW];
        m_wdata = wdata_in[m_core*DW +: DW];
        m_busy  = 1'b1;
        m_s     = cyc;
        m_a     = cyc + 1 + (m_we ? 0 : LAT);
        m_next  = m_a + 2;
        e_wren  = m_we;
        e_rden  = !m_we;
        e_strobe = 1'b1;
        if (m_we) shadow[m_addr] = m_wdata;
      end else begin
        m_next = cyc + 1;
      end
    end else if (m_busy && cyc == m_a) begin
      e_ack[m_core] = 1'b1;
      if (!m_we) begin
        e_rdv   = 1'b1;
        e_rdata = shadow[m_addr];
      end
      if (m_stat[m_core] < 65535) m_stat[m_core]++;
    end
  endtask

  task automatic check_outputs();
    logic [N*16-1:0] e_stat;
    e_stat = '0;
`ifdef DRAM_ARB_STATS_EN
    for (int i = 0; i < N; i++) e_stat[i*16 +: 16] = 16'(m_stat[i]);
`endif
    check("ack", ack, e_ack);
    check("busy", busy, m_busy);
    check("mem_wren", mem_wren, e_wren);
    check("mem_rden", mem_rden, e_rden);
    check("stat_grant", stat_grant, e_stat);
    if (e_strobe) begin
      check("mem_addr", mem_addr, m_addr);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_rdv) check("rdata", rdata, e_rdata);
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic set_core(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[c] = w;
    addr_in[c*AW +: AW] = a;
    wdata_in[c*DW +: DW] = d;
    req[c] = 1'b1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    shadow[a] = d;
    tick();
    poke_en = 1'b0;
  endtask

  // One transaction from an idle arbiter; returns edges from raising req to strobe and to ack.
  task automatic one_txn(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output int strobe_lat);
    int start;
    start = cyc; lat = -1; strobe_lat = -1;
    set_core(c, w, a, d);
    for (int g = 0; g < 12 && lat < 0; g++) begin
      tick();
      if ((mem_wren || mem_rden) && strobe_lat < 0) strobe_lat = cyc - start;
      if (ack[c]) begin
        lat = cyc - start;
        req[c] = 1'b0;
      end
    end
    req[c] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int order[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int guard;
    int lat, slat;

    for (int i = 0; i < (1<<AW); i++) shadow[i] = pattern(i);
    for (int i = 0; i < N; i++) begin m_stat[i] = 0; cd[i] = 0; end

    // Reset held three edges with every core requesting a read.
    reset_n = 1'b0;
    ram_init = 1'b1;
    for (int c = 0; c < N; c++) set_core(c, 1'b0, AW'(c * 3 + 1), '0);
    tick();
    ram_init = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Continuous contention: grants must rotate starting at core 0.
    guard = 0;
    while (order.size() < 8 && guard < 100) begin
      tick();
      guard++;
      for (int c = 0; c < N; c++) if (ack[c]) order.push_back(c);
      for (int c = 0; c < N; c++) begin
        if (e_ack[c]) begin req[c] = 1'b0; cd[c] = 2; end
        else if (cd[c] > 0) cd[c]--;
        if (!req[c] && cd[c] == 0) req[c] = 1'b1;
      end
    end
    if (order.size() < 6) check("rr_order_len", order.size(), 6);
    else for (int i = 0; i < 6; i++) check("rr_order", order[i], exp_order[i]);
    req = '0;
    for (int i = 0; i < 8; i++) tick();

    // Reset while a read sits in WAIT: no ack, strobes and busy cleared.
    set_core(0, 1'b0, 9'h010, '0);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!(m_busy && cyc == m_s + 1) && guard < 20);
    if (guard >= 20) check("mid_rst_reach", 0, 1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_ack", ack, 0);
    check("mid_rst_rden", mem_rden, 0);
    check("mid_rst_busy", busy, 0);
    req = '0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Single read by core 1 from a preloaded word.
    poke(9'h05A, 16'h1234);
    one_txn(1, 1'b0, 9'h05A, '0, lat, slat);
    check("t3_ack_lat", lat, 2 + LAT);
    check("t3_rden_lat", slat, 1);
    check("t3_rdata", rdata, 16'h1234);

    // Single write by core 2.
    one_txn(2, 1'b1, 9'h05A, 16'hBEEF, lat, slat);
    check("t2_ack_lat", lat, 2);
    check("t2_wren_lat", slat, 1);

    // Five grants to core 3 after a fresh reset.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) one_txn(3, 1'b1, AW'(i), DW'(i + 16'h0A00), lat, slat);
`ifdef DRAM_ARB_STATS_EN
    check("t6_stat3", stat_grant[3*16 +: 16], 5);
`else
    check("t6_stat_all", stat_grant, 0);
`endif

    // Random traffic with mid-transaction field changes and early req drops.
    for (int c = 0; c < N; c++) cd[c] = 0;
    for (int t = 0; t < 800; t++) begin
      tick();
      for (int c = 0; c < N; c++) begin
        if (e_ack[c]) begin req[c] = 1'b0; cd[c] = 2; end
        else if (cd[c] > 0) cd[c]--;
      end
      if (m_busy && cyc == m_s) begin
        we[m_core] = 1'($urandom_range(0, 1));
        addr_in[m_core*AW +: AW] = AW'($urandom);
        wdata_in[m_core*DW +: DW] = DW'($urandom);
        if ($urandom_range(0, 3) == 0) begin req[m_core] = 1'b0; cd[m_core] = 3; end
      end
      for (int c = 0; c < N; c++)
        if (!req[c] && cd[c] == 0 && $urandom_range(0, 2) == 0)
          set_core(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end
    req = '0;
    for (int i = 0; i < 12; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
